mem_port_arbiter: RTL and testbench

// - Shares the core's single word-wide memory port between instruction fetch and data load/store.
// - Sits between riscv_core's fetch/LSU requesters and the memory model's mem_addr/mem_data_in/mem_data_out/mem_write_en port.
// - Sequences reads, full-word writes and read-modify-write for partial stores.
// - Data side has priority, with a starvation guard for fetch. New grants are gated by halted.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/mem_port_arbiter_be_merge.sv | 22 ++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the core's memory-port logic.
// Byte-lane words are packed [0:3][7:0]: element i is byte lane i, so a
// literal {8'h11, 8'h22, 8'h33, 8'h44} places 8'h11 in lane 0.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef logic [0:3][7:0] byte_word_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Little-endian view of a lane word: lane 0 becomes bits [7:0].
    function automatic logic [31:0] le_word(input byte_word_t w);
        return {w[3], w[2], w[1], w[0]};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_be_merge.sv
// Combinational byte-lane merge for partial stores: each lane takes the
// store byte when its enable is set, otherwise keeps the byte read back.
module be_merge
    import riscv_pkg::*;
(
    input  byte_word_t old_word,
    input  byte_word_t new_word,
    input  logic [3:0] be,
    output byte_word_t merged
);

    // Select each lane independently under its byte enable.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[i] = new_word[i];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single word-wide memory port between instruction fetch and
// data load/store. Data has priority; a starvation counter forces a fetch
// grant after STARVE_LIMIT consecutive data grants with fetch waiting.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | arbitrate (only while not halted), latch granted request
//   RD    | hold mem_addr for MEM_LATENCY cycles, capture on last one
//   WR    | single-cycle write strobe with the (merged) store word
//   RESP  | one-cycle ready pulse to the granted requester
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
)
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        halted,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  byte_word_t  d_wdata,
    output logic        d_ready,
    output byte_word_t  d_rdata,
    output logic [31:0] mem_addr,
    output byte_word_t  mem_data_in,
    output logic        mem_write_en,
    input  byte_word_t  mem_data_out
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             gnt_d;
    logic             gnt_f;
    logic             rd_last;
    logic             gnt_data_q;
    logic             we_q;
    logic [3:0]       be_q;
    byte_word_t       wdata_q;
    byte_word_t       rdata_q;
    byte_word_t       merged_word;
    logic [31:0]      addr_q;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;

    assign rd_last = (state == RD) && (lat_cnt == '0);

    be_merge u_be_merge (
        .old_word (mem_data_out),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged_word)
    );

    // Next-state and grant decision; grants are only issued from IDLE.
    always_comb begin
        state_nxt = state;
        gnt_d     = 1'b0;
        gnt_f     = 1'b0;
        case (state)
            IDLE: begin
                if (!halted) begin
                    if (d_req && !(if_req && (starve_cnt == STV_MAX))) begin
                        gnt_d = 1'b1;
                    end else if (if_req) begin
                        gnt_f = 1'b1;
                    end
                end
                if (gnt_d) begin
                    if (d_we && (d_be == 4'h0)) begin
                        state_nxt = RESP;
                    end else if (d_we && (d_be == 4'hF)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end else if (gnt_f) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                // Only partial stores read with we_q set; they go on to write.
                if (lat_cnt == '0) begin
                    state_nxt = we_q ? WR : RESP;
                end
            end
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the granted request, run the latency down-counter, capture reads.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            gnt_data_q <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            lat_cnt    <= '0;
        end else begin
            if (gnt_d) begin
                gnt_data_q <= 1'b1;
                we_q       <= d_we;
                be_q       <= d_be;
                wdata_q    <= d_wdata;
                addr_q     <= d_addr & WORD_ALIGN_MASK;
            end else if (gnt_f) begin
                gnt_data_q <= 1'b0;
                we_q       <= 1'b0;
                be_q       <= 4'h0;
                addr_q     <= if_addr & WORD_ALIGN_MASK;
            end

            if (gnt_d || gnt_f) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == RD) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (rd_last) begin
                if (we_q) begin
                    wdata_q <= merged_word;
                end else begin
                    rdata_q <= mem_data_out;
                end
            end
        end
    end

    // Count data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            starve_cnt <= '0;
        end else if (gnt_d) begin
            starve_cnt <= if_req ? (starve_cnt + STV_W'(1)) : '0;
        end else if (gnt_f) begin
            starve_cnt <= '0;
        end
    end

    assign if_ready     = (state == RESP) && !gnt_data_q;
    assign d_ready      = (state == RESP) &&  gnt_data_q;
    assign mem_write_en = (state == WR);
    assign mem_data_in  = (state == WR) ? wdata_q : '0;
    assign mem_addr     = addr_q;
    assign if_rdata     = le_word(rdata_q);
    assign d_rdata      = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a 64-word memory model and
// a scoreboard of expected ready pulses.
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    typedef struct {
        bit          is_data;
        bit          chk_data;
        logic [31:0] data;
    } sb_item_t;

    logic        clk;
    logic        rst_b;
    logic        halted;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    byte_word_t  d_wdata;
    logic        d_ready;
    byte_word_t  d_rdata;
    logic [31:0] mem_addr;
    byte_word_t  mem_data_in;
    logic        mem_write_en;
    byte_word_t  mem_data_out;

    byte_word_t  tb_mem  [0:63];
    byte_word_t  ref_mem [0:63];
    bit          mem_init_done = 1'b0;
    sb_item_t    sb [$];
    sb_item_t    mon_it;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .halted       (halted),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ready     (if_ready),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_be         (d_be),
        .d_wdata      (d_wdata),
        .d_ready      (d_ready),
        .d_rdata      (d_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic byte_word_t init_word(input int i);
        if (i == 4)  return {8'h93, 8'h00, 8'hA0, 8'h00};
        if (i == 16) return {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        return {8'(i), 8'h5A, 8'(~i), 8'hC3};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: combinational read, write on the strobe edge.
    assign mem_data_out = tb_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (mem_write_en) begin
            tb_mem[mem_addr[7:2]] <= mem_data_in;
        end
    end

    // Monitor: write strobes, idle write data, ready pulses against the scoreboard.
    always @(negedge clk) begin
        if (mem_write_en) wr_cnt++;
        else chk("wdata_idle", mem_data_in, 32'h0);
        if (if_ready || d_ready) begin
            chk("ready_excl", {31'b0, if_ready & d_ready}, 32'h0);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_it = sb.pop_front();
                chk("ready_kind", {31'b0, d_ready}, {31'b0, mon_it.is_data});
                if (mon_it.chk_data) begin
                    if (mon_it.is_data) chk("d_rdata", d_rdata, mon_it.data);
                    else                chk("if_rdata", if_rdata, mon_it.data);
                end
            end
        end
    end

    function automatic sb_item_t fetch_item(input logic [31:0] addr);
        sb_item_t   it;
        byte_word_t m;
        m           = ref_mem[addr[7:2]];
        it.is_data  = 1'b0;
        it.chk_data = 1'b1;
        it.data     = {m[3], m[2], m[1], m[0]};
        return it;
    endfunction

    function automatic sb_item_t load_item(input logic [31:0] addr);
        sb_item_t it;
        it.is_data  = 1'b1;
        it.chk_data = 1'b1;
        it.data     = ref_mem[addr[7:2]];
        return it;
    endfunction

    // Called at a negedge with the DUT idle; ends one idle cycle after ready.
    task automatic do_fetch(input logic [31:0] addr, input int exp_lat);
        int n;
        bit got;
        sb.push_back(fetch_item(addr));
        if_req  = 1'b1;
        if_addr = addr;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("if_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            if (if_ready) got = 1'b1;
        end
        if_req = 1'b0;
        chk("if_done", {31'b0, got}, 32'd1);
        chk("if_lat", n, exp_lat);
        @(negedge clk);
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input byte_word_t wd, input int exp_lat);
        int         n;
        int         w0;
        bit         got;
        sb_item_t   it;
        byte_word_t m;
        it = load_item(addr);
        it.chk_data = !we;
        if (we) begin
            m = ref_mem[addr[7:2]];
            for (int i = 0; i < 4; i++) if (be[i]) m[i] = wd[i];
            ref_mem[addr[7:2]] = m;
        end
        sb.push_back(it);
        w0 = wr_cnt;
        d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wd;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("d_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            if (mem_write_en) chk("d_wr_addr", mem_addr, addr & 32'hFFFF_FFFC);
            if (d_ready) got = 1'b1;
        end
        d_req = 1'b0;
        chk("d_done", {31'b0, got}, 32'd1);
        chk("d_lat", n, exp_lat);
        chk("d_wr_cnt", wr_cnt - w0, (we && be != 4'h0) ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int n;
        int dseen;
        int fseen;
        int wseen;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        rst_b = 1'b0; halted = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
        chk("rst_d_ready", {31'b0, d_ready}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_write_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        rst_b = 1'b1;
        @(negedge clk);

        do_fetch(32'h0000_0013, 2);
        do_data(1'b1, 32'h20, 4'hF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 2);
        chk("fstore_mem", tb_mem[8], 32'hDEADBEEF);
        do_data(1'b0, 32'h23, 4'h0, '0, 2);
        do_data(1'b1, 32'h40, 4'b0101, {8'h11, 8'h22, 8'h33, 8'h44}, 3);
        chk("pstore_mem", tb_mem[16], 32'h11BB33DD);
        do_data(1'b0, 32'h40, 4'h0, '0, 2);
        do_data(1'b1, 32'h44, 4'h0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1);
        chk("nostore_mem", tb_mem[17], ref_mem[17]);

        // Contention: both held, data back-to-back; expect D,D,D,D,F,D.
        for (int i = 0; i < 4; i++) sb.push_back(load_item(32'h20));
        sb.push_back(fetch_item(32'h10));
        sb.push_back(load_item(32'h20));
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_be = 4'h0;
        if_req = 1'b1; if_addr = 32'h10;
        cnt = 0; n = 0;
        while (cnt < 6 && n < 100) begin
            @(negedge clk);
            n++;
            if (if_ready || d_ready) cnt++;
        end
        d_req = 1'b0; if_req = 1'b0;
        chk("cont_done", cnt, 32'd6);
        @(negedge clk);

        // halted raised during a data read: data completes, fetch stays pending.
        sb.push_back(load_item(32'h40));
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'h0;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        halted = 1'b1;
        dseen = 0; fseen = 0; wseen = 0;
        for (int i = 0; i < 12; i++) begin
            if (d_ready) begin dseen++; d_req = 1'b0; end
            if (if_ready) fseen++;
            if (mem_write_en) wseen++;
            @(negedge clk);
        end
        chk("halt_d_ready", dseen, 32'd1);
        chk("halt_if_ready", fseen, 32'd0);
        chk("halt_we", wseen, 32'd0);
        if_req = 1'b0;
        halted = 1'b0;
        @(negedge clk);

        // Reset during a partial-store read.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_be = 4'b0011;
        d_wdata = {8'h55, 8'h66, 8'h77, 8'h88};
        @(negedge clk);
        chk("prst_in_rd", mem_addr, 32'h40);
        #1 rst_b = 1'b0;
        #1;
        chk("arst_mem_we", {31'b0, mem_write_en}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_d_ready", {31'b0, d_ready}, 32'd0);
        chk("arst_if_ready", {31'b0, if_ready}, 32'd0);
        chk("arst_mem_din", mem_data_in, 32'h0);
        chk("arst_d_rdata", d_rdata, 32'h0);
        chk("arst_if_rdata", if_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_mem_kept", tb_mem[16], 32'h11BB33DD);

        sb.push_back(load_item(32'h20));
        sb.push_back(fetch_item(32'h10));
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_be = 4'h0;
        if_req = 1'b1; if_addr = 32'h10;
        rst_b = 1'b1;
        cnt = 0; n = 0;
        while (cnt < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (d_ready) begin cnt++; d_req = 1'b0; end
            if (if_ready) begin cnt++; if_req = 1'b0; end
        end
        d_req = 1'b0; if_req = 1'b0;
        chk("post_rst_done", cnt, 32'd2);
        repeat (2) @(negedge clk);

        chk("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
